// File: rtl/seg7_down_count_monitor.sv
// Receive-side checker for an active-low 7448-style seven-segment bus: debounces, decodes,
// verifies the count steps by one per change and counts errors. Option: SEG7MON_DIR_DETECT_EN.
module seg7_down_count_monitor #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned ERR_CNT_W     = 8
) (
    input  logic                 CP,
    input  logic                 rstn,
    input  logic [6:0]           i_Z,
    input  logic                 i_resync,
    output logic [3:0]           o_Q,
    output logic                 o_valid,
    output logic                 o_blank,
    output logic                 o_illegal,
    output logic                 o_seq_err,
    output logic [ERR_CNT_W-1:0] o_err_cnt,
    output logic                 o_dir
);

    localparam int unsigned CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

`ifdef SEG7MON_DIR_DETECT_EN
    typedef enum logic [1:0] {SYNC_WAIT, DETECT, TRACK} state_t;
`else
    typedef enum logic [1:0] {SYNC_WAIT, TRACK} state_t;
`endif

    state_t               state_q, state_d;
    logic [6:0]           seg_q, seg_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [6:0]           last_q, last_d;
    logic [3:0]           ref_q, ref_d;
    logic [3:0]           q_q, q_d;
    logic                 blank_q, blank_d;
    logic                 valid_q, valid_d;
    logic                 illegal_q, illegal_d;
    logic                 seq_err_q, seq_err_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    logic                 dir_q, dir_d;
    logic                 accept;
    logic                 err_inc;
    logic                 legal;
    logic [3:0]           val;
    logic [3:0]           exp_val;
    logic [4:0]           dec;

    // Returns {legal, value} for an active-high gfedcba pattern.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h3F: decode = {1'b1, 4'h0};
            7'h06: decode = {1'b1, 4'h1};
            7'h5B: decode = {1'b1, 4'h2};
            7'h4F: decode = {1'b1, 4'h3};
            7'h66: decode = {1'b1, 4'h4};
            7'h6D: decode = {1'b1, 4'h5};
            7'h7C: decode = {1'b1, 4'h6};
            7'h07: decode = {1'b1, 4'h7};
            7'h7F: decode = {1'b1, 4'h8};
            7'h67: decode = {1'b1, 4'h9};
            7'h58: decode = {1'b1, 4'hA};
            7'h4C: decode = {1'b1, 4'hB};
            7'h62: decode = {1'b1, 4'hC};
            7'h69: decode = {1'b1, 4'hD};
            7'h78: decode = {1'b1, 4'hE};
            7'h00: decode = {1'b1, 4'hF};
            default: decode = 5'h00;
        endcase
    endfunction

    assign seg_d = ~i_Z;

    // Reset sample is all-off, so a blank bus after reset counts toward stability but never accepts.
    always_ff @(posedge CP or negedge rstn) begin
        if (!rstn) begin
            seg_q <= '0;
            cnt_q <= '0;
        end else begin
            seg_q <= seg_d;
            if (seg_d != seg_q) begin
                cnt_q <= '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign accept  = (cnt_q == CNT_MAX) && (seg_q != last_q);
    assign dec     = decode(seg_q);
    assign legal   = dec[4];
    assign val     = dec[3:0];
    assign exp_val = dir_q ? (ref_q + 4'd1) : (ref_q - 4'd1);

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        ref_d     = ref_q;
        q_d       = q_q;
        blank_d   = blank_q;
        dir_d     = dir_q;
        valid_d   = 1'b0;
        illegal_d = 1'b0;
        seq_err_d = 1'b0;
        err_inc   = 1'b0;

        if (accept) begin
            last_d = seg_q;
            if (!legal) begin
                illegal_d = 1'b1;
                err_inc   = 1'b1;
                state_d   = SYNC_WAIT;
            end else begin
                valid_d = 1'b1;
                q_d     = val;
                blank_d = (seg_q == 7'h00);
                ref_d   = val;
                if (i_resync) begin
                    state_d = TRACK;
                end else begin
                    case (state_q)
`ifdef SEG7MON_DIR_DETECT_EN
                        SYNC_WAIT: state_d = DETECT;
                        DETECT: begin
                            if (val == ref_q + 4'd1) begin
                                dir_d   = 1'b1;
                                state_d = TRACK;
                            end else if (val == ref_q - 4'd1) begin
                                dir_d   = 1'b0;
                                state_d = TRACK;
                            end else begin
                                seq_err_d = 1'b1;
                                err_inc   = 1'b1;
                            end
                        end
`else
                        SYNC_WAIT: state_d = TRACK;
`endif
                        TRACK: begin
                            if (val != exp_val) begin
                                seq_err_d = 1'b1;
                                err_inc   = 1'b1;
                            end
                        end
                        default: state_d = SYNC_WAIT;
                    endcase
                end
            end
        end else if (i_resync) begin
            state_d = SYNC_WAIT;
        end

        err_d = (err_inc && (err_q != '1)) ? (err_q + ERR_CNT_W'(1)) : err_q;
    end

    always_ff @(posedge CP or negedge rstn) begin
        if (!rstn) begin
            state_q   <= SYNC_WAIT;
            last_q    <= '0;
            ref_q     <= '0;
            q_q       <= '0;
            blank_q   <= 1'b0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            seq_err_q <= 1'b0;
            err_q     <= '0;
            dir_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            ref_q     <= ref_d;
            q_q       <= q_d;
            blank_q   <= blank_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            seq_err_q <= seq_err_d;
            err_q     <= err_d;
            dir_q     <= dir_d;
        end
    end

    assign o_Q       = q_q;
    assign o_valid   = valid_q;
    assign o_blank   = blank_q;
    assign o_illegal = illegal_q;
    assign o_seq_err = seq_err_q;
    assign o_err_cnt = err_q;
    assign o_dir     = dir_q;

endmodule
